// File: rtl/control_unit.sv
// Multi-cycle control unit: IDLE/HALT, T0..T7 Moore sequencer driving datapath strobes from ir[31:27].
// Optional build macro CU_MULDIV_EN enables mul/div and the HI/LO load strobes.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        run,
    input  logic        stop,
    output logic        pco,
    output logic        mari,
    output logic        pc_inc,
    output logic        mem_read,
    output logic        mdri,
    output logic        mdro,
    output logic        iri,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        baout,
    output logic        csigno,
    output logic        ryi,
    output logic        rzi,
    output logic        rzo,
    output logic        mem_write,
    output logic        ipo,
    output logic        opi,
    output logic        hii,
    output logic        loi,
    output logic        running,
    output logic        illegal
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

`ifdef CU_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    state_t     state_reg, state_next;
    logic       illegal_reg, illegal_next;
    logic [4:0] opcode;
    logic [31:0] legal_vec;
    logic       op_legal, is_alu, is_ld, is_ldi, is_st, is_muldiv, is_short;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign unused_ir = ^ir[26:0];

    // One legality bit per opcode value, so the decode is a single table lookup.
    for (genvar gi = 0; gi < 32; gi++) begin : g_legal
        localparam logic [4:0] OPC = 5'(gi);
        assign legal_vec[gi] = (OPC <= OP_SHL) || (OPC == OP_IN) || (OPC == OP_OUT) ||
                               (OPC == OP_NOP) || (OPC == OP_HALT) ||
                               (MULDIV_EN && ((OPC == OP_MUL) || (OPC == OP_DIV)));
    end

    assign op_legal = legal_vec[opcode];
    assign is_ld    = (opcode == OP_LD);
    assign is_ldi   = (opcode == OP_LDI);
    assign is_st    = (opcode == OP_ST);
    assign is_alu   = (opcode >= OP_ADD) && (opcode <= OP_SHL);
    assign is_short = (opcode == OP_IN) || (opcode == OP_OUT) || (opcode == OP_NOP);
`ifdef CU_MULDIV_EN
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
`else
    assign is_muldiv = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_reg   <= ST_IDLE;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_t end_state;
        end_state    = stop ? ST_HALT : ST_T0;
        state_next   = state_reg;
        illegal_next = illegal_reg;
        case (state_reg)
            ST_IDLE, ST_HALT: if (run && !stop) state_next = ST_T0;
            ST_T0: state_next = ST_T1;
            ST_T1: state_next = ST_T2;
            ST_T2: state_next = ST_T3;
            ST_T3: begin
                if (!op_legal) begin
                    state_next   = ST_HALT;
                    illegal_next = 1'b1;
                end else if (opcode == OP_HALT) begin
                    state_next = ST_HALT;
                end else if (is_short) begin
                    state_next = end_state;
                end else begin
                    state_next = ST_T4;
                end
            end
            ST_T4: state_next = ST_T5;
            ST_T5: state_next = (is_alu || is_ldi) ? end_state : ST_T6;
            ST_T6: state_next = is_muldiv ? end_state : ST_T7;
            ST_T7: state_next = end_state;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pco = 1'b0; mari = 1'b0; pc_inc = 1'b0; mem_read = 1'b0; mdri = 1'b0;
        mdro = 1'b0; iri = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0;
        rout = 1'b0; baout = 1'b0; csigno = 1'b0; ryi = 1'b0; rzi = 1'b0; rzo = 1'b0;
        mem_write = 1'b0; ipo = 1'b0; opi = 1'b0; hii = 1'b0; loi = 1'b0;
        case (state_reg)
            ST_T0: begin pco = 1'b1; mari = 1'b1; pc_inc = 1'b1; end
            ST_T1: begin mem_read = 1'b1; mdri = 1'b1; end
            ST_T2: begin mdro = 1'b1; iri = 1'b1; end
            ST_T3: begin
                if (is_alu) begin
                    grb = 1'b1; rout = 1'b1; ryi = 1'b1;
                end else if (is_ld || is_ldi || is_st) begin
                    grb = 1'b1; baout = 1'b1; ryi = 1'b1;
                end else if (is_muldiv) begin
                    gra = 1'b1; rout = 1'b1; ryi = 1'b1;
                end else if (opcode == OP_IN) begin
                    ipo = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (opcode == OP_OUT) begin
                    gra = 1'b1; rout = 1'b1; opi = 1'b1;
                end
            end
            ST_T4: begin
                if (is_alu) begin
                    grc = 1'b1; rout = 1'b1; rzi = 1'b1;
                end else if (is_ld || is_ldi || is_st) begin
                    csigno = 1'b1; rzi = 1'b1;
                end else if (is_muldiv) begin
                    grb = 1'b1; rout = 1'b1; rzi = 1'b1;
                end
            end
            ST_T5: begin
                if (is_alu || is_ldi) begin
                    rzo = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (is_ld || is_st) begin
                    rzo = 1'b1; mari = 1'b1;
                end else if (is_muldiv) begin
                    loi = 1'b1;
                end
            end
            ST_T6: begin
                if (is_ld) begin
                    mem_read = 1'b1; mdri = 1'b1;
                end else if (is_st) begin
                    gra = 1'b1; rout = 1'b1; mdri = 1'b1;
                end else if (is_muldiv) begin
                    hii = 1'b1;
                end
            end
            ST_T7: begin
                if (is_ld) begin
                    mdro = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (is_st) begin
                    mem_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign running = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    assign illegal = illegal_reg;

endmodule
